// File: rtl/obstacle_arbiter_if.sv
// obstacle_arbiter_if: bundles the range-measurement inputs and the maneuver outputs
// of obstacle_arbiter.
//   meas       N_CH*W  packed measurements, channel i at [W*i+W-1:W*i]
//   meas_vld   N_CH    per-channel sample strobe
//   near       N_CH    filtered near flags
//   mo         4       motor direction code
//   pwm_s      2       PWM speed select
//   led_s      1       maneuver-active LED
//   active_ch  ACW     channel owning the current maneuver
// master: range front end / bench side. slave: the arbiter.
interface obstacle_arbiter_if #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned W    = 20
);
  localparam int unsigned ACW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH*W-1:0] meas;
  logic [N_CH-1:0]   meas_vld;
  logic [N_CH-1:0]   near;
  logic [3:0]        mo;
  logic [1:0]        pwm_s;
  logic              led_s;
  logic [ACW-1:0]    active_ch;

  modport master (
    output meas, meas_vld,
    input  near, mo, pwm_s, led_s, active_ch
  );

  modport slave (
    input  meas, meas_vld,
    output near, mo, pwm_s, led_s, active_ch
  );
endinterface

// File: rtl/obstacle_arbiter.sv
// obstacle_arbiter: filters N_CH range channels into near flags (confirmation count plus
// hysteresis) and drives one motor/PWM/LED maneuver owned by the lowest-index near channel,
// held for HOLD_CYC cycles after every channel clears.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  obstacle_arbiter_if.slave (meas, meas_vld in; near, mo, pwm_s, led_s, active_ch out)
module obstacle_arbiter #(
  parameter int unsigned         N_CH      = 4,
  parameter int unsigned         W         = 20,
  parameter int unsigned         THRESH    = 90000,
  parameter int unsigned         HYST      = 5000,
  parameter int unsigned         CONFIRM   = 3,
  parameter int unsigned         HOLD_CYC  = 50000,
  parameter logic [4*N_CH-1:0]   MO_TABLE  = 16'h96A5,
  parameter logic [2*N_CH-1:0]   PWM_TABLE = 8'hE5
) (
  input logic             clk,
  input logic             rst,
  obstacle_arbiter_if.slave bus
);

  localparam int unsigned ACW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned CW  = $clog2(CONFIRM + 1);
  localparam int unsigned HCW = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;

  // Thresholds held at W+1 bits so THRESH+HYST cannot wrap.
  localparam logic [W:0]     NearLvl  = (W+1)'(THRESH);
  localparam logic [W:0]     ClrLvl   = (W+1)'(THRESH + HYST);
  localparam logic [CW-1:0]  ConfCnt  = CW'(CONFIRM);
  localparam logic [HCW-1:0] HoldInit = HCW'(HOLD_CYC);

  typedef enum logic [1:0] {StIdle, StAvoid, StHold} state_e;

  // ---------------------------------------------------------------- channel filters
  logic [CW-1:0]   below_q [N_CH];
  logic [CW-1:0]   below_d [N_CH];
  logic [CW-1:0]   above_q [N_CH];
  logic [CW-1:0]   above_d [N_CH];
  logic [N_CH-1:0] near_q, near_d;
  logic [W:0]      sample;

  always_comb begin
    near_d = near_q;
    sample = '0;
    for (int i = 0; i < N_CH; i++) begin
      below_d[i] = below_q[i];
      above_d[i] = above_q[i];
      sample     = {1'b0, bus.meas[W*i +: W]};
      if (bus.meas_vld[i]) begin
        if (sample < NearLvl) begin
          below_d[i] = (below_q[i] == ConfCnt) ? below_q[i] : below_q[i] + CW'(1);
          above_d[i] = '0;
        end else if (sample >= ClrLvl) begin
          above_d[i] = (above_q[i] == ConfCnt) ? above_q[i] : above_q[i] + CW'(1);
          below_d[i] = '0;
        end else begin
          // Inside the hysteresis band: restart both runs, keep the flag.
          below_d[i] = '0;
          above_d[i] = '0;
        end
        if (below_d[i] == ConfCnt) begin
          near_d[i] = 1'b1;
        end else if (above_d[i] == ConfCnt) begin
          near_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      near_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        below_q[i] <= '0;
        above_q[i] <= '0;
      end
    end else begin
      near_q <= near_d;
      for (int i = 0; i < N_CH; i++) begin
        below_q[i] <= below_d[i];
        above_q[i] <= above_d[i];
      end
    end
  end

  // ---------------------------------------------------------------- winner select
  logic [ACW-1:0] win;
  logic           any_near;
  logic [3:0]     win_mo;
  logic [1:0]     win_pwm;

  always_comb begin
    win = '0;
    // Scan downwards so the lowest set index is the last to write.
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (near_q[i]) win = ACW'(i);
    end
    any_near = |near_q;
    win_mo   = 4'(MO_TABLE >> (4 * int'(win)));
    win_pwm  = 2'(PWM_TABLE >> (2 * int'(win)));
  end

  // ---------------------------------------------------------------- maneuver FSM
  state_e         state_q, state_d;
  logic [3:0]     mo_q, mo_d;
  logic [1:0]     pwm_q, pwm_d;
  logic           led_q, led_d;
  logic [ACW-1:0] ach_q, ach_d;
  logic [HCW-1:0] hold_q, hold_d;

  always_comb begin
    state_d = state_q;
    mo_d    = mo_q;
    pwm_d   = pwm_q;
    led_d   = led_q;
    ach_d   = ach_q;
    hold_d  = hold_q;
    unique case (state_q)
      StIdle: begin
        if (any_near) begin
          state_d = StAvoid;
          mo_d    = win_mo;
          pwm_d   = win_pwm;
          led_d   = 1'b1;
          ach_d   = win;
        end
      end
      StAvoid: begin
        if (any_near) begin
          // Re-track every cycle: covers preemption and handoff alike.
          mo_d  = win_mo;
          pwm_d = win_pwm;
          ach_d = win;
        end else if (HOLD_CYC == 0) begin
          state_d = StIdle;
          mo_d    = '0;
          pwm_d   = '0;
          led_d   = 1'b0;
          ach_d   = '0;
        end else begin
          state_d = StHold;
          hold_d  = HoldInit;
        end
      end
      StHold: begin
        if (any_near) begin
          state_d = StAvoid;
          mo_d    = win_mo;
          pwm_d   = win_pwm;
          led_d   = 1'b1;
          ach_d   = win;
          hold_d  = '0;
        end else if (hold_q <= HCW'(1)) begin
          state_d = StIdle;
          mo_d    = '0;
          pwm_d   = '0;
          led_d   = 1'b0;
          ach_d   = '0;
          hold_d  = '0;
        end else begin
          hold_d = hold_q - HCW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        mo_d    = '0;
        pwm_d   = '0;
        led_d   = 1'b0;
        ach_d   = '0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      mo_q    <= '0;
      pwm_q   <= '0;
      led_q   <= 1'b0;
      ach_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      mo_q    <= mo_d;
      pwm_q   <= pwm_d;
      led_q   <= led_d;
      ach_q   <= ach_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.near      = near_q;
  assign bus.mo        = mo_q;
  assign bus.pwm_s     = pwm_q;
  assign bus.led_s     = led_q;
  assign bus.active_ch = ach_q;

endmodule

// File: tb/tb_obstacle_arbiter.sv
// Bench for obstacle_arbiter: directed strobes, a history-based output model checked on every
// negedge, and literal expectations at the key points of each scenario.
module tb_obstacle_arbiter;

  localparam int N    = 4;
  localparam int W    = 20;
  localparam int TH   = 90000;
  localparam int HY   = 5000;
  localparam int CF   = 3;
  localparam int HOLD = 8;
  localparam logic [15:0] MOT = 16'h96A5;
  localparam logic [7:0]  PWT = 8'hE5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  obstacle_arbiter_if #(.N_CH(N), .W(W)) bus ();

  obstacle_arbiter #(
    .N_CH(N), .W(W), .THRESH(TH), .HYST(HY), .CONFIRM(CF), .HOLD_CYC(HOLD),
    .MO_TABLE(MOT), .PWM_TABLE(PWT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ------------------------------------------------------------------ model
  // Filter: per-channel run lengths. Outputs: derived from the near history -- the winner of
  // the previous cycle's flags, or the last winner while the all-clear run is within HOLD.
  int          m_below [N];
  int          m_above [N];
  logic [N-1:0] m_near;
  logic [3:0]  e_mo;
  logic [1:0]  e_pwm;
  logic        e_led;
  logic [1:0]  e_ach;
  int          idle_run;
  int          last_win;
  bit          have;

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_below[i] = 0;
        m_above[i] = 0;
      end
      m_near = '0; e_mo = '0; e_pwm = '0; e_led = 1'b0; e_ach = '0;
      idle_run = 0; last_win = 0; have = 0;
    end else begin
      if (m_near != '0) begin
        last_win = lowest(m_near);
        have     = 1;
        idle_run = 0;
      end else begin
        idle_run++;
      end
      if (have && idle_run <= HOLD) begin
        e_mo  = 4'(MOT >> (4 * last_win));
        e_pwm = 2'(PWT >> (2 * last_win));
        e_led = 1'b1;
        e_ach = 2'(last_win);
      end else begin
        have = 0; e_mo = '0; e_pwm = '0; e_led = 1'b0; e_ach = '0;
      end
      for (int i = 0; i < N; i++) begin
        if (bus.meas_vld[i]) begin
          int s;
          s = int'(bus.meas[W*i +: W]);
          if (s < TH) begin
            m_below[i] = (m_below[i] + 1 > CF) ? CF : m_below[i] + 1;
            m_above[i] = 0;
          end else if (s >= TH + HY) begin
            m_above[i] = (m_above[i] + 1 > CF) ? CF : m_above[i] + 1;
            m_below[i] = 0;
          end else begin
            m_below[i] = 0;
            m_above[i] = 0;
          end
          if (m_below[i] == CF) m_near[i] = 1'b1;
          if (m_above[i] == CF) m_near[i] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("near", bus.near, m_near);
      chk("mo", bus.mo, e_mo);
      chk("pwm_s", bus.pwm_s, e_pwm);
      chk("led_s", bus.led_s, e_led);
      chk("active_ch", bus.active_ch, e_ach);
    end
  end

  // ------------------------------------------------------------------ stimulus
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int ch, input int val);
    bus.meas[W*ch +: W] = W'(val);
    bus.meas_vld        = '0;
    bus.meas_vld[ch]    = 1'b1;
    @(posedge clk);
    #1;
    bus.meas_vld = '0;
  endtask

  task automatic confirm(input int ch, input int val);
    repeat (CF) strobe(ch, val);
  endtask

  initial begin
    bus.meas     = '0;
    bus.meas_vld = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("lit_rst_near", bus.near, 4'b0000);
    chk("lit_rst_mo", bus.mo, 4'b0000);
    chk("lit_rst_pwm", bus.pwm_s, 2'b00);
    chk("lit_rst_led", bus.led_s, 1'b0);
    chk("lit_rst_ach", bus.active_ch, 2'd0);
    rst = 1'b0;
    tick(2);

    // Confirmation on ch2
    strobe(2, 80000);
    strobe(2, 80000);
    chk("lit_ch2_two", bus.near, 4'b0000);
    strobe(2, 80000);
    chk("lit_ch2_near", bus.near, 4'b0100);
    chk("lit_ch2_mo_lag", bus.mo, 4'b0000);
    tick(1);
    chk("lit_ch2_mo", bus.mo, 4'b0110);
    chk("lit_ch2_pwm", bus.pwm_s, 2'b10);
    chk("lit_ch2_led", bus.led_s, 1'b1);
    chk("lit_ch2_ach", bus.active_ch, 2'd2);
    confirm(2, 100000);
    tick(12);
    chk("lit_ch2_idle", bus.mo, 4'b0000);

    // Hysteresis and hold on ch0
    confirm(0, 80000);
    tick(1);
    chk("lit_ch0_mo", bus.mo, 4'b0101);
    strobe(0, 92000);
    strobe(0, 90000);
    strobe(0, 94999);
    strobe(0, 95000);
    strobe(0, 95000);
    chk("lit_ch0_band", bus.near, 4'b0001);
    strobe(0, 95000);
    chk("lit_ch0_clear", bus.near, 4'b0000);
    chk("lit_ch0_avoid_tail", bus.mo, 4'b0101);
    for (int k = 1; k <= HOLD; k++) begin
      tick(1);
      chk("lit_hold_mo", bus.mo, 4'b0101);
      chk("lit_hold_led", bus.led_s, 1'b1);
    end
    tick(1);
    chk("lit_hold_end_mo", bus.mo, 4'b0000);
    chk("lit_hold_end_led", bus.led_s, 1'b0);

    // Preemption and handoff
    confirm(3, 80000);
    tick(1);
    chk("lit_ch3_mo", bus.mo, 4'b1001);
    chk("lit_ch3_pwm", bus.pwm_s, 2'b11);
    confirm(1, 80000);
    chk("lit_pre_lag", bus.mo, 4'b1001);
    tick(1);
    chk("lit_pre_mo", bus.mo, 4'b1010);
    chk("lit_pre_pwm", bus.pwm_s, 2'b01);
    chk("lit_pre_ach", bus.active_ch, 2'd1);
    confirm(1, 100000);
    chk("lit_hand_near", bus.near, 4'b1000);
    tick(1);
    chk("lit_hand_mo", bus.mo, 4'b1001);
    chk("lit_hand_ach", bus.active_ch, 2'd3);

    // Hold interrupted by ch1
    strobe(1, 80000);
    strobe(1, 80000);
    confirm(3, 100000);
    tick(4);
    strobe(1, 80000);
    chk("lit_int_held", bus.mo, 4'b1001);
    chk("lit_int_led", bus.led_s, 1'b1);
    tick(1);
    chk("lit_int_mo", bus.mo, 4'b1010);
    chk("lit_int_ach", bus.active_ch, 2'd1);
    confirm(1, 100000);
    tick(12);
    chk("lit_int_idle", bus.mo, 4'b0000);

    // Asynchronous reset mid-AVOID
    confirm(0, 80000);
    tick(1);
    chk("lit_rs_mo", bus.mo, 4'b0101);
    #1 rst = 1'b1;
    #1;
    chk("lit_rs_async_mo", bus.mo, 4'b0000);
    chk("lit_rs_async_led", bus.led_s, 1'b0);
    chk("lit_rs_async_near", bus.near, 4'b0000);
    #1 rst = 1'b0;
    strobe(0, 80000);
    strobe(0, 80000);
    chk("lit_rs_fresh_near", bus.near, 4'b0000);
    chk("lit_rs_fresh_mo", bus.mo, 4'b0000);
    strobe(0, 80000);
    tick(1);
    chk("lit_rs_again_mo", bus.mo, 4'b0101);
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/obstacle_arbiter.md
# obstacle_arbiter

Parametrised N-channel obstacle arbiter that turns per-channel range measurements (echo-count distances) into one motor-direction code, PWM select and status LED. Each channel is filtered with a confirmation count and hysteresis, so a single noisy sample cannot toggle its near/clear state. A priority FSM picks the lowest-index near channel and keeps its maneuver for a minimum hold time after the obstacle clears. The block sits between the range-capture front ends and the motor/PWM driver.

## Interface
- N_CH, 4: number of range channels (1..8).
- W, 20: measurement width in bits, unsigned.
- THRESH, 90000: near threshold; a sample below it counts as near.
- HYST, 5000: hysteresis; a sample at or above THRESH+HYST counts as clear.
- CONFIRM, 3: consecutive qualifying samples needed to change a near flag (>=1).
- HOLD_CYC, 50000: clock cycles the maneuver is held after all channels clear (0 skips hold).
- MO_TABLE, 16'h96A5: per-channel 4-bit motor code; channel i is at [4i+3:4i].
- PWM_TABLE, 8'hE5: per-channel 2-bit PWM select; channel i is at [2i+1:2i].

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- meas  in  N_CH*W  packed measurements; channel i is at [W*i+W-1:W*i].
- meas_vld  in  N_CH  one-cycle strobe per channel; the measurement is sampled on this strobe.
- near  out  N_CH  registered filtered near flags.
- mo  out  4  motor direction code.
- pwm_s  out  2  PWM speed select.
- led_s  out  1  high while a maneuver is active (AVOID or HOLD).
- active_ch  out  max(1,clog2(N_CH))  channel that owns the current maneuver; 0 in IDLE.

## Operation
- Per-channel filter, acting only on cycles where meas_vld[i]=1:
  - sample < THRESH: increment below_cnt (saturates at CONFIRM), clear above_cnt.
  - sample >= THRESH+HYST: increment above_cnt (saturates at CONFIRM), clear below_cnt.
  - sample in [THRESH, THRESH+HYST): clear both counts, leave near[i] unchanged.
  - near[i] sets when below_cnt reaches CONFIRM and clears when above_cnt reaches CONFIRM.
- Arithmetic: compares are unsigned. THRESH+HYST is formed at W+1 bits and never wraps. Counters are clog2(CONFIRM+1) bits wide.
- Winner: the lowest index i with near[i]=1.
- FSM:
  - IDLE: mo=0000, pwm_s=00, led_s=0. If any near, latch the winner and go to AVOID.
  - AVOID: mo=MO_TABLE[winner], pwm_s=PWM_TABLE[winner], led_s=1. active_ch re-tracks the winner every cycle, which covers both preemption by a lower index and handoff to a higher index when the owner clears. When no near remains: go to HOLD and load hold_cnt=HOLD_CYC, or go to IDLE if HOLD_CYC=0.
  - HOLD: outputs stay frozen at the last maneuver and hold_cnt decrements each cycle. Any near returns the FSM to AVOID with the new winner. In HOLD, if hold_cnt=1 and no near, go to IDLE.
- Simultaneous events:
  - A near flag rising on the same cycle that hold expires: AVOID takes precedence.
  - Several channels rising together: the lowest index wins.
- Reset: all counters, near, hold_cnt and active_ch go to 0; state goes to IDLE; mo=0000, pwm_s=00, led_s=0. Reset takes effect immediately, including mid-maneuver.

## Timing
- near[i] updates at the clock edge that samples the CONFIRM-th qualifying meas_vld and is visible the following cycle.
- mo, pwm_s, led_s and active_ch are registered and update one cycle after near changes, giving 2 cycles of latency from the qualifying strobe to the output.
- HOLD lasts exactly HOLD_CYC cycles. mo returns to 0000 on the following edge.
- Preemption: the motor code changes 1 cycle after the lower-index near flag rises. No intermediate IDLE code is emitted.

## Test plan
Bench parameters: THRESH=90000, HYST=5000, CONFIRM=3, HOLD_CYC=8.

- Reset: assert rst asynchronously -> near=0, mo=0000, pwm_s=00, led_s=0, active_ch=0.
- Confirmation, ch2: two strobes at 80000 -> near[2] stays 0. A third strobe -> near[2]=1 next cycle, then mo=0110, pwm_s=10, led_s=1, active_ch=2 one cycle after that.
- Hysteresis and hold, ch0 near (mo=0101):
  - strobes at 92000 -> near[0] stays 1.
  - three strobes at 95000 -> near[0]=0, then exactly 8 HOLD cycles with mo=0101, then mo=0000 and led_s=0.
- Preemption: ch3 active (mo=1001, pwm_s=11); ch1 confirms near -> mo=1010, pwm_s=01, active_ch=1. When ch1 clears with ch3 still near -> mo=1001 directly, with no HOLD.
- Hold interrupt: in HOLD at hold_cnt=4, ch1 confirms near -> AVOID with mo=1010; the hold counter is discarded.
- Reset mid-AVOID: rst pulse -> outputs go to zero immediately. After release, ch0 needs three fresh strobes at 80000 before mo=0101 again.
